reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement queue sitting after rename. It accepts one renamed instruction per cycle at the tail and records completion reports from the execution units. It retires one completed instruction per cycle from the head. At retirement it drives `commit_en` and `commit_old_preg` back into rename's free list. It drives `branch_mispredict` into rename when a mispredicted branch retires.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; must be a power of two.
- `TAG_W`, default 4: tag width, log2(DEPTH).
- `PREG_W`, default 7: physical register index width.
- `PC_W`, default 9: PC width.

Ports (clock is `clk`, reset is `reset`; one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `dispatch_valid` in 1: rename offers an instruction.
- `dispatch_ready` out 1: an entry is free.
- `dispatch_prd` in PREG_W: new physical destination.
- `dispatch_old_prd` in PREG_W: previous mapping of the destination.
- `dispatch_reg_write` in 1: instruction writes a register.
- `dispatch_is_branch` in 1: instruction is a branch.
- `dispatch_pc` in PC_W: instruction PC.
- `alloc_tag` out TAG_W: tail index; the tag the next dispatched instruction receives.
- `wb_valid` in 1: completion report.
- `wb_tag` in TAG_W: tag of the completing entry.
- `wb_mispredict` in 1: the completing branch was mispredicted.
- `commit_en` out 1: head entry retires this cycle.
- `commit_old_preg` out PREG_W: physical register to free.
- `commit_tag` out TAG_W: head tag.
- `commit_pc` out PC_W: PC of the retiring instruction.
- `branch_mispredict` out 1: one-cycle flush pulse.
- `rob_empty` out 1: no valid entries.

## Operation
- Per-entry state: `valid`, `done`, `mispredict`, `reg_write`, `is_branch`, `prd`, `old_prd`, `pc`.
- Pointers `head` and `tail` are TAG_W bits wide and wrap modulo DEPTH.
- `count` is TAG_W+1 bits wide, range 0..DEPTH.

Dispatch:
- A dispatch fires when `dispatch_valid && dispatch_ready`.
- On fire, the entry at `tail` is written with `valid=1` and `done=0`, then `tail` increments.
- `dispatch_ready = (count != DEPTH)`. The ready signal does not account for a commit in the same cycle.

Writeback:
- A writeback sets `done` on entry `wb_tag` and stores `wb_mispredict` into its `mispredict` bit.
- A writeback to a non-valid entry is ignored.

Commit:
- `commit_en = valid[head] && done[head]`.
- On commit, `valid[head]` clears and `head` increments.
- `commit_old_preg = old_prd[head]` when `reg_write[head]` is set; otherwise 0.
- Rename must ignore a freed preg of 0.

Mispredict flush:
- When the committing entry has `is_branch && mispredict`, `branch_mispredict=1` in the same cycle. The branch itself commits normally.
- On the next clock, all `valid` bits clear, `tail` is set to `head+1` (the post-commit head), and `count` becomes 0.
- A dispatch or writeback in the flush cycle is discarded.

Simultaneous events:
- Dispatch and commit in the same cycle leave `count` unchanged.
- A writeback and a commit of a different entry in the same cycle are independent.

## Timing
- Reset: `head=tail=count=0`, all `valid=0`. Consequently `dispatch_ready=1`, `alloc_tag=0`, `commit_en=0`, `commit_old_preg=0`, `commit_tag=0`, `commit_pc=0`, `branch_mispredict=0`, `rob_empty=1`.
- Reset asserted mid-operation discards all entries, with no commits.
- Writeback in cycle N sets `done` at edge N+1. The earliest `commit_en` for that entry is cycle N+1.
- Minimum dispatch-to-commit latency is 2 cycles: dispatch at N, writeback at N+1, commit at N+2.
- `dispatch_ready`, `alloc_tag`, `rob_empty` and all commit outputs are combinational from registered state only. There is no path from any input to any output.
- Throughput is one dispatch and one commit per cycle, sustained.

## Structure
- Shared package `ooo_pkg` holds:
  - constants `ROB_DEPTH`, `ROB_TAG_W`, `PREG_W`, `PC_W`;
  - struct `rob_entry_t` with the fields listed under Operation.
- Entry storage is a flop array of `rob_entry_t`, required for per-entry `done` updates.
- Sub-module `rob_ptr` is a wrap-around TAG_W-bit pointer with increment and load, instantiated for `head` and `tail`.

## Test plan
- Reset, then 16 back-to-back dispatches with no writeback: `dispatch_ready` drops after the 16th. `alloc_tag` wraps 15→0. A 17th `dispatch_valid` is not accepted.
- Dispatch tags 0,1,2 with `old_prd`=40,41,42 and `reg_write`=1; write back 2, then 0, then 1: commits occur in order 0,1,2 with `commit_old_preg` 40,41,42. The commit of tag 0 occurs the cycle after its writeback.
- Full ROB with the head done, plus `dispatch_valid` in the same cycle: the commit fires, the dispatch is refused that cycle and accepted the next, and `count` stays 16.
- Branch at tag 3 written back with `wb_mispredict=1`, younger entries 4–6 valid: `commit_en` and `branch_mispredict` are high together for tag 3. The next cycle has `rob_empty=1`, `alloc_tag=4`, and entries 4–6 never commit.
- Entry with `reg_write=0` commits with `commit_old_preg=0`. A writeback to an empty slot changes nothing.
- `reset` asserted with 5 entries in flight: all outputs return to reset values the next cycle, and no `commit_en` pulse occurs.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types and sizes.
// Reorder buffer geometry and entry layout.
package ooo_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = 4;
    localparam int PREG_W    = 7;
    localparam int PC_W      = 9;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispredict;
        logic              reg_write;
        logic              is_branch;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around ROB pointer with increment and load.
// Load takes priority over increment.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i)
            ptr_d = load_val_i;
        else if (inc_i)
            ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: tail dispatch, out-of-order completion,
// head commit, flush on a retiring mispredicted branch.
module reorder_buffer #(
    parameter int DEPTH  = ooo_pkg::ROB_DEPTH,
    parameter int TAG_W  = ooo_pkg::ROB_TAG_W,
    parameter int PREG_W = ooo_pkg::PREG_W,
    parameter int PC_W   = ooo_pkg::PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic [PREG_W-1:0] dispatch_prd,
    input  logic [PREG_W-1:0] dispatch_old_prd,
    input  logic              dispatch_reg_write,
    input  logic              dispatch_is_branch,
    input  logic [PC_W-1:0]   dispatch_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              wb_mispredict,
    output logic              commit_en,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [PC_W-1:0]   commit_pc,
    output logic              branch_mispredict,
    output logic              rob_empty
);

    import ooo_pkg::rob_entry_t;

    rob_entry_t       rob_q [DEPTH];
    rob_entry_t       rob_d [DEPTH];
    logic [TAG_W:0]   count_q, count_d;
    logic [TAG_W-1:0] head, tail, head_nxt;
    rob_entry_t       head_e;
    logic             flush, disp_fire, wb_hit;

    assign head_e    = rob_q[head];
    assign head_nxt  = head + 1'b1;
    assign commit_en = head_e.valid & head_e.done;
    assign flush     = commit_en & head_e.is_branch & head_e.mispredict;
    assign disp_fire = dispatch_valid & dispatch_ready & ~flush;
    assign wb_hit    = wb_valid & rob_q[wb_tag].valid & ~flush;

    rob_ptr #(.W(TAG_W)) u_head (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (commit_en),
        .load_i    (1'b0),
        .load_val_i('0),
        .ptr_o     (head)
    );

    // On flush the tail collapses onto the post-commit head.
    rob_ptr #(.W(TAG_W)) u_tail (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (disp_fire),
        .load_i    (flush),
        .load_val_i(head_nxt),
        .ptr_o     (tail)
    );

    always_comb begin
        rob_d = rob_q;
        if (wb_hit) begin
            rob_d[wb_tag].done       = 1'b1;
            rob_d[wb_tag].mispredict = wb_mispredict;
        end
        if (disp_fire) begin
            rob_d[tail].valid      = 1'b1;
            rob_d[tail].done       = 1'b0;
            rob_d[tail].mispredict = 1'b0;
            rob_d[tail].reg_write  = dispatch_reg_write;
            rob_d[tail].is_branch  = dispatch_is_branch;
            rob_d[tail].prd        = dispatch_prd;
            rob_d[tail].old_prd    = dispatch_old_prd;
            rob_d[tail].pc         = dispatch_pc;
        end
        if (commit_en)
            rob_d[head].valid = 1'b0;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                rob_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit_en);
        if (flush)
            count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                rob_q[i] <= '0;
        end else begin
            count_q <= count_d;
            rob_q   <= rob_d;
        end
    end

    assign dispatch_ready    = count_q != (TAG_W+1)'(DEPTH);
    assign rob_empty         = count_q == '0;
    assign alloc_tag         = tail;
    assign commit_tag        = head;
    assign branch_mispredict = flush;
    assign commit_pc         = commit_en ? head_e.pc : '0;
    assign commit_old_preg   = (commit_en && head_e.reg_write)
                             ? head_e.old_prd : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue model.
module tb_reorder_buffer;

    logic       clk = 0;
    logic       rst;
    logic       dv, drw, dbr, wv, wmp;
    logic [6:0] dprd, dold;
    logic [8:0] dpc;
    logic [3:0] wtag;
    logic       ready, cen, bm, empty;
    logic [3:0] atag, ctag;
    logic [6:0] cold;
    logic [8:0] cpc;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] tag;
        logic [6:0] old;
        logic       rw, br, done, mp;
        logic [8:0] pc;
    } m_t;

    m_t         mq[$];
    int         mhead = 0;
    int         mtail = 0;
    logic [6:0] cq[$];

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (rst),
        .dispatch_valid    (dv),
        .dispatch_ready    (ready),
        .dispatch_prd      (dprd),
        .dispatch_old_prd  (dold),
        .dispatch_reg_write(drw),
        .dispatch_is_branch(dbr),
        .dispatch_pc       (dpc),
        .alloc_tag         (atag),
        .wb_valid          (wv),
        .wb_tag            (wtag),
        .wb_mispredict     (wmp),
        .commit_en         (cen),
        .commit_old_preg   (cold),
        .commit_tag        (ctag),
        .commit_pc         (cpc),
        .branch_mispredict (bm),
        .rob_empty         (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ce, fl;
        ce = mq.size() > 0 && mq[0].done;
        fl = ce && mq[0].br && mq[0].mp;
        chk("commit_en", 32'(cen), 32'(ce));
        chk("branch_mispredict", 32'(bm), 32'(fl));
        chk("commit_tag", 32'(ctag), 32'(mhead));
        chk("alloc_tag", 32'(atag), 32'(mtail));
        chk("dispatch_ready", 32'(ready), 32'(mq.size() != 16));
        chk("rob_empty", 32'(empty), 32'(mq.size() == 0));
        if (ce) begin
            chk("commit_old_preg", 32'(cold),
                32'(mq[0].rw ? mq[0].old : 7'd0));
            chk("commit_pc", 32'(cpc), 32'(mq[0].pc));
        end
        if (cen === 1'b1)
            cq.push_back(cold);
    endtask

    task automatic model_update();
        logic ce, fl;
        int   sz;
        m_t   e;
        if (rst) begin
            mq.delete();
            mhead = 0;
            mtail = 0;
            return;
        end
        sz = mq.size();
        ce = sz > 0 && mq[0].done;
        fl = ce && mq[0].br && mq[0].mp;
        if (wv && !fl) begin
            foreach (mq[i]) begin
                if (mq[i].tag == wtag) begin
                    mq[i].done = 1'b1;
                    mq[i].mp   = wmp;
                end
            end
        end
        if (dv && sz != 16 && !fl) begin
            e.tag = 4'(mtail);
            e.old = dold;
            e.rw = drw;
            e.br = dbr;
            e.pc = dpc;
            e.done = 1'b0;
            e.mp = 1'b0;
            mq.push_back(e);
            mtail = (mtail + 1) % 16;
        end
        if (ce) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % 16;
        end
        if (fl) begin
            mq.delete();
            mtail = mhead;
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        dv = 0;
        wv = 0;
        rst = 0;
    endtask

    task automatic disp(input logic [6:0] old, input logic rw,
                        input logic br);
        dv = 1;
        dold = old;
        drw = rw;
        dbr = br;
        dprd = 7'($urandom);
        dpc = 9'($urandom);
    endtask

    task automatic wb(input logic [3:0] t, input logic mp);
        wv = 1;
        wtag = t;
        wmp = mp;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        logic found;
        dv = 0; drw = 0; dbr = 0; dprd = 0; dold = 0; dpc = 0;
        wv = 0; wtag = 0; wmp = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        chk("rst_ready", 32'(ready), 1);
        chk("rst_alloc", 32'(atag), 0);
        chk("rst_commit_en", 32'(cen), 0);
        chk("rst_old_preg", 32'(cold), 0);
        chk("rst_commit_tag", 32'(ctag), 0);
        chk("rst_commit_pc", 32'(cpc), 0);
        chk("rst_bm", 32'(bm), 0);
        chk("rst_empty", 32'(empty), 1);

        // Fill to full, then try a 17th.
        for (int i = 0; i < 16; i++) begin
            disp(7'(i), 1, 0);
            tick();
        end
        idle();
        chk("full_ready", 32'(ready), 0);
        chk("wrap_alloc", 32'(atag), 0);
        disp(7'd99, 1, 0);
        tick();
        idle();
        chk("no17_ready", 32'(ready), 0);
        chk("no17_alloc", 32'(atag), 0);

        // Full with head done plus a dispatch in the same cycle.
        wb(0, 0);
        tick();
        idle();
        disp(7'd77, 1, 0);
        chk("full_commit_en", 32'(cen), 1);
        chk("full_refused", 32'(ready), 0);
        tick();
        chk("after_ready", 32'(ready), 1);
        tick();
        idle();
        chk("refill_ready", 32'(ready), 0);
        chk("refill_alloc", 32'(atag), 1);

        // Out-of-order completion, in-order retirement.
        do_reset();
        disp(7'd40, 1, 0); tick();
        disp(7'd41, 1, 0); tick();
        disp(7'd42, 1, 0); tick();
        idle();
        cq.delete();
        wb(2, 0); tick();
        wb(0, 0); tick();
        chk("c0_next_cycle", 32'(cen), 1);
        chk("c0_tag", 32'(ctag), 0);
        wb(1, 0); tick();
        idle();
        repeat (4) tick();
        chk("order_count", 32'(cq.size()), 3);
        for (int i = 0; i < 3; i++)
            chk("order_preg", 32'(cq[i]), 32'(40 + i));

        // reg_write=0 frees preg 0; writeback to empty slot ignored.
        do_reset();
        disp(7'd55, 0, 0); tick();
        idle();
        wb(0, 0); tick();
        idle();
        chk("nowrite_en", 32'(cen), 1);
        chk("nowrite_preg", 32'(cold), 0);
        tick();
        wb(9, 1); tick();
        idle();
        chk("wb_empty_empty", 32'(empty), 1);
        chk("wb_empty_cen", 32'(cen), 0);
        tick();

        // Mispredicted branch at tag 3 with younger entries 4..6.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            disp(7'(i + 1), 1, i == 3);
            tick();
        end
        idle();
        wb(0, 0); tick();
        wb(1, 0); tick();
        wb(2, 0); tick();
        wb(3, 1); tick();
        idle();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (cen === 1'b1 && ctag === 4'd3)
                found = 1;
            else
                tick();
        end
        chk("bm_found", 32'(found), 1);
        chk("bm_pulse", 32'(bm), 1);
        chk("bm_commit", 32'(cen), 1);
        wb(4, 0); tick();
        idle();
        chk("flush_empty", 32'(empty), 1);
        chk("flush_alloc", 32'(atag), 4);
        wb(5, 0); tick();
        wb(6, 0); tick();
        idle();
        chk("flush_no_commit", 32'(cen), 0);
        tick();

        // Reset with 5 in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            disp(7'(i + 20), 1, 0);
            tick();
        end
        idle();
        rst = 1;
        wb(0, 0);
        tick();
        idle();
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_alloc", 32'(atag), 0);
        chk("mid_rst_cen", 32'(cen), 0);
        chk("mid_rst_ready", 32'(ready), 1);
        tick();
        chk("mid_rst_cen2", 32'(cen), 0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) != 0)
                disp(7'($urandom), 1'($urandom),
                     $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                    wb(mq[$urandom_range(0, mq.size() - 1)].tag,
                       $urandom_range(0, 9) == 0);
                else
                    wb(4'($urandom), 1'($urandom));
            end
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
